// File: rtl/pipe_tail_valrdy_queue.sv
// Pipeline-tail adapter: the last stall/squash stage pushes into a small circular buffer,
// and the buffer is re-exposed to the consumer as a val/rdy stream.
module pipe_tail_valrdy_queue #(
    parameter int p_msg_nbits   = 32,
    parameter int p_num_entries = 2,
    parameter int p_cnt_nbits   = 2
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [p_msg_nbits-1:0] prev_msg,
    input  logic                   prev_val,
    output logic                   prev_stall,
    output logic                   prev_squash,
    input  logic                   flush,
    output logic [p_msg_nbits-1:0] deq_msg,
    output logic                   deq_val,
    input  logic                   deq_rdy,
    output logic [p_cnt_nbits-1:0] num_free
);

    localparam int ptr_nbits = $clog2(p_num_entries);
    localparam logic [p_cnt_nbits-1:0] full_cnt = p_cnt_nbits'(p_num_entries);

    logic [p_msg_nbits-1:0] mem [p_num_entries];
    logic [ptr_nbits-1:0]   head;
    logic [ptr_nbits-1:0]   tail;
    logic [p_cnt_nbits-1:0] count;
    logic [p_cnt_nbits-1:0] count_next;
    logic                   enq_fire;
    logic                   deq_fire;

    // Handshakes: a transfer happens on a side exactly in a cycle where its valid and
    // its ready (~prev_stall upstream, deq_rdy downstream) are both high and flush is low.
    // Stall depends only on registered count, so deq_rdy never reaches prev_stall.
    assign prev_stall  = (count == full_cnt);
    assign prev_squash = flush;
    assign deq_val     = (count != '0) & ~flush;
    assign deq_msg     = (count != '0) ? mem[head] : '0;
    assign num_free    = full_cnt - count;

    assign enq_fire = prev_val & ~prev_stall & ~flush;
    assign deq_fire = deq_val & deq_rdy;

    always_comb begin
        count_next = count;
        if (enq_fire && !deq_fire) begin
            count_next = count + 1'b1;
        end else if (deq_fire && !enq_fire) begin
            count_next = count - 1'b1;
        end
    end

    // Depth is a power of two, so pointer wrap is plain overflow.
    always_ff @(posedge clk) begin
        if (reset || flush) begin
            count <= '0;
            head  <= '0;
            tail  <= '0;
        end else begin
            count <= count_next;
            if (enq_fire) begin
                tail <= tail + 1'b1;
            end
            if (deq_fire) begin
                head <= head + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (enq_fire) begin
            mem[tail] <= prev_msg;
        end
    end

`ifndef SYNTHESIS
    always @(posedge clk) begin
        if (!reset && enq_fire && !deq_fire) begin
            assert (count != full_cnt);
        end
    end

    function automatic string line_trace();
        string s;
        s = $sformatf("%0d ", num_free);
        if (flush) begin
            s = {s, "X"};
        end else if (deq_fire) begin
            s = {s, $sformatf("%h", deq_msg)};
        end else if (deq_val && !deq_rdy) begin
            s = {s, "#"};
        end else begin
            s = {s, " "};
        end
        return s;
    endfunction
`endif

endmodule
